// File: rtl/wb_arbiter.sv
// Writeback arbiter owning the register-file write port; merges pipeline WB with buffered long-latency results.
// Latency: 1 cycle from winning arbitration to RegWrite/waddr/wdata; long-latency results take at least 2 cycles (no bypass).
// Backpressure: lu_ready drops while the FIFO is full; pipe_stall holds the pipeline during a forced drain.
//
// Ports:
//   Clk, Rst                        clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data    in-order pipeline writeback (rd==0 is a no-op)
//   pipe_stall                      pipeline must re-present its WB entry next cycle
//   lu_valid/lu_rd/lu_data/lu_ready long-latency result handshake
//   RegWrite/waddr/wdata            registered register-file write port
//   pending                         destinations currently buffered in the FIFO
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        RegWrite,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [31:0] pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd  [DEPTH];
    logic [31:0]   fifo_dat [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic pipe_req;
    logic fifo_ne;
    logic full;
    logic force_drain;
    logic push;
    logic pop;

    always_comb begin
        pipe_req    = pipe_valid & (pipe_rd != 5'd0);
        fifo_ne     = (count != '0);
        full        = (count == CW'(DEPTH));
        force_drain = fifo_ne & (starve_cnt == SW'(STARVE_LIMIT));
        lu_ready    = !full & !Rst;
        pipe_stall  = force_drain & !Rst;
        // rd==0 results complete the handshake but never occupy an entry.
        push        = lu_valid & lu_ready & (lu_rd != 5'd0);
        // The FIFO drains whenever the pipeline has nothing real to write,
        // or unconditionally once the pipeline has starved it long enough.
        pop         = !Rst & fifo_ne & (force_drain | !pipe_req);
    end

    // Walk the occupied slots starting at the head; reflects contents
    // before this cycle's push/pop.
    always_comb begin
        logic [PW-1:0] idx;
        pending = '0;
        idx     = '0;
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if (i < int'(count)) begin
                    pending[fifo_rd[idx]] = 1'b1;
                end
            end
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            RegWrite   <= 1'b0;
            waddr      <= 5'd0;
            wdata      <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            // Counts consecutive pipeline wins over a non-empty FIFO.
            if (pop || !fifo_ne) begin
                starve_cnt <= '0;
            end else if (pipe_req && (starve_cnt != SW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (pop) begin
                RegWrite <= 1'b1;
                waddr    <= fifo_rd[rd_ptr];
                wdata    <= fifo_dat[rd_ptr];
            end else if (pipe_req) begin
                RegWrite <= 1'b1;
                waddr    <= pipe_rd;
                wdata    <= pipe_data;
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_rd[wr_ptr]  <= lu_rd;
            fifo_dat[wr_ptr] <= lu_data;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios against fixed expectations, then
// randomized traffic against a queue-based reference model.
// Inputs change 1 time unit after posedge; outputs are sampled mid-cycle.
module tb_wb_arbiter;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic        Clk;
    logic        Rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        RegWrite;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pending;

    int vectors;
    int miscompares;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .RegWrite   (RegWrite),
        .waddr      (waddr),
        .wdata      (wdata),
        .pending    (pending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: buffered results as a queue, plus a starvation tally.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dat;
    } ent_t;

    ent_t        mq[$];
    int          mstarve;
    logic        mwe;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic        exp_ready;
    logic        exp_stall;
    logic [31:0] exp_pending;

    task automatic model_comb();
        exp_ready   = !Rst && (mq.size() < DEPTH);
        exp_stall   = !Rst && (mq.size() > 0) && (mstarve == STARVE);
        exp_pending = 32'd0;
        if (!Rst) begin
            foreach (mq[k]) exp_pending = exp_pending | (32'd1 << mq[k].rd);
        end
    endtask

    task automatic model_step();
        bit preq;
        bit ne;
        bit popped;
        int size_before;
        ent_t e;
        if (Rst) begin
            mq.delete();
            mstarve = 0;
            mwe     = 1'b0;
            maddr   = 5'd0;
            mdata   = 32'd0;
        end else begin
            preq        = pipe_valid && (pipe_rd != 5'd0);
            size_before = mq.size();
            ne          = size_before > 0;
            popped      = 0;
            if (ne && (mstarve == STARVE || !preq)) begin
                e      = mq.pop_front();
                mwe    = 1'b1;
                maddr  = e.rd;
                mdata  = e.dat;
                popped = 1;
            end else if (preq) begin
                mwe   = 1'b1;
                maddr = pipe_rd;
                mdata = pipe_data;
            end else begin
                mwe = 1'b0;
            end
            if (popped || !ne) mstarve = 0;
            else if (preq && mstarve < STARVE) mstarve++;
            if (lu_valid && size_before < DEPTH && lu_rd != 5'd0) begin
                e.rd  = lu_rd;
                e.dat = lu_data;
                mq.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic rst, input logic pv, input logic [4:0] prd,
                         input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
                         input logic [31:0] ld);
        Rst        = rst;
        pipe_valid = pv;
        pipe_rd    = prd;
        pipe_data  = pd;
        lu_valid   = lv;
        lu_rd      = lrd;
        lu_data    = ld;
        #2;
        model_comb();
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (lu_ready !== 1'b0 || pipe_stall !== 1'b0 || pending !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_comb: got ready=%b stall=%b pending=%h, want 0 0 0", lu_ready, pipe_stall, pending);
        end
        tick();
        tick();
        vectors++;
        if (RegWrite !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got we=%b addr=%0d data=%h, want 0 0 0", RegWrite, waddr, wdata);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (lu_ready !== 1'b1 || pipe_stall !== 1'b0 || pending !== 32'd0) begin
            miscompares++;
            $display("FAIL idle_comb: got ready=%b stall=%b pending=%h, want 1 0 0", lu_ready, pipe_stall, pending);
        end
        tick();
        vectors++;
        if (RegWrite !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL idle_regs: got we=%b addr=%0d data=%h, want 0 0 0", RegWrite, waddr, wdata);
        end
    endtask

    task automatic test_pipe_only();
        drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        tick();
        vectors++;
        if (RegWrite !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL pipe_write: got we=%b addr=%0d data=%h, want 1 5 deadbeef", RegWrite, waddr, wdata);
        end
        drive(0, 1, 5'd0, 32'h0BADF00D, 0, 0, 0);
        tick();
        vectors++;
        if (RegWrite !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL pipe_rd0: got we=%b addr=%0d data=%h, want 0 5 deadbeef", RegWrite, waddr, wdata);
        end
    endtask

    task automatic test_lu_path();
        drive(0, 0, 0, 0, 1, 5'd7, 32'h12345678);
        vectors++;
        if (lu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_ready_empty: got %b want 1", lu_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (pending !== 32'h80 || RegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_pending: got pending=%h we=%b, want 00000080 0", pending, RegWrite);
        end
        tick();
        vectors++;
        if (RegWrite !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL lu_write: got we=%b addr=%0d data=%h, want 1 7 12345678", RegWrite, waddr, wdata);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (pending !== 32'd0) begin
            miscompares++;
            $display("FAIL lu_pending_clear: got %h want 0", pending);
        end
        tick();
    endtask

    task automatic test_fifo_full();
        drive(0, 1, 5'd10, 32'hA0, 1, 5'd1, 32'h11);
        tick();
        vectors++;
        if (RegWrite !== 1'b1 || waddr !== 5'd10) begin
            miscompares++;
            $display("FAIL full_pipe_wins: got we=%b addr=%0d, want 1 10", RegWrite, waddr);
        end
        drive(0, 1, 5'd10, 32'hA1, 1, 5'd2, 32'h22);
        tick();
        drive(0, 1, 5'd10, 32'hA2, 1, 5'd3, 32'h33);
        vectors++;
        if (lu_ready !== 1'b0 || pending !== 32'h6 || pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state: got ready=%b pending=%h stall=%b, want 0 00000006 0", lu_ready, pending, pipe_stall);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (pending !== 32'h6) begin
            miscompares++;
            $display("FAIL full_reject: got pending=%h want 00000006", pending);
        end
        tick();
        vectors++;
        if (RegWrite !== 1'b1 || waddr !== 5'd1 || wdata !== 32'h11) begin
            miscompares++;
            $display("FAIL full_pop1: got we=%b addr=%0d data=%h, want 1 1 11", RegWrite, waddr, wdata);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if (RegWrite !== 1'b1 || waddr !== 5'd2 || wdata !== 32'h22) begin
            miscompares++;
            $display("FAIL full_pop2: got we=%b addr=%0d data=%h, want 1 2 22", RegWrite, waddr, wdata);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if (RegWrite !== 1'b0 || pending !== 32'd0) begin
            miscompares++;
            $display("FAIL full_drained: got we=%b pending=%h, want 0 0", RegWrite, pending);
        end
    endtask

    task automatic test_starvation();
        drive(0, 0, 0, 0, 1, 5'd3, 32'h33);
        tick();
        for (int i = 1; i <= STARVE; i++) begin
            drive(0, 1, 5'd9, 32'h900 + i, 0, 0, 0);
            vectors++;
            if (pipe_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL starve_early_stall: cycle %0d got stall=%b want 0", i, pipe_stall);
            end
            tick();
            vectors++;
            if (RegWrite !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h900 + i) begin
                miscompares++;
                $display("FAIL starve_pipe: cycle %0d got we=%b addr=%0d data=%h", i, RegWrite, waddr, wdata);
            end
        end
        drive(0, 1, 5'd9, 32'h905, 0, 0, 0);
        vectors++;
        if (pipe_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL starve_stall: got %b want 1", pipe_stall);
        end
        tick();
        vectors++;
        if (RegWrite !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h33) begin
            miscompares++;
            $display("FAIL starve_drain: got we=%b addr=%0d data=%h, want 1 3 33", RegWrite, waddr, wdata);
        end
        drive(0, 1, 5'd9, 32'h905, 0, 0, 0);
        vectors++;
        if (pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_release: got stall=%b want 0", pipe_stall);
        end
        tick();
        vectors++;
        if (RegWrite !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h905) begin
            miscompares++;
            $display("FAIL starve_represent: got we=%b addr=%0d data=%h, want 1 9 905", RegWrite, waddr, wdata);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 5'd4, 32'h44, 1, 5'd11, 32'hB1);
        tick();
        drive(0, 1, 5'd4, 32'h45, 1, 5'd12, 32'hB2);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (pending !== 32'd0 || lu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_comb: got pending=%h ready=%b stall=%b, want 0 0 0", pending, lu_ready, pipe_stall);
        end
        tick();
        vectors++;
        if (RegWrite !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_regs: got we=%b addr=%0d data=%h, want 0 0 0", RegWrite, waddr, wdata);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (lu_ready !== 1'b1 || pending !== 32'd0) begin
                miscompares++;
                $display("FAIL midrst_after: cycle %0d got ready=%b pending=%h, want 1 0", i, lu_ready, pending);
            end
            tick();
            vectors++;
            if (RegWrite !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_nowrite: cycle %0d got we=%b want 0", i, RegWrite);
            end
        end
    endtask

    task automatic test_random();
        logic        rst;
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic        hold;
        hold = 1'b0;
        pv   = 1'b0;
        prd  = 5'd0;
        pd   = 32'd0;
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!hold) begin
                pv  = ($urandom_range(0, 9) < 7);
                prd = 5'($urandom_range(0, 31));
                pd  = $urandom;
            end
            lv  = ($urandom_range(0, 1) == 1);
            lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive(rst, pv, prd, pd, lv, lrd, $urandom);
            vectors++;
            if (lu_ready !== exp_ready || pipe_stall !== exp_stall || pending !== exp_pending) begin
                miscompares++;
                $display("FAIL rand_comb: cycle %0d got ready=%b stall=%b pending=%h, want %b %b %h",
                         c, lu_ready, pipe_stall, pending, exp_ready, exp_stall, exp_pending);
            end
            // A stalled pipeline re-presents the same writeback.
            hold = exp_stall && pv;
            tick();
            vectors++;
            if (RegWrite !== mwe || waddr !== maddr || wdata !== mdata) begin
                miscompares++;
                $display("FAIL rand_regs: cycle %0d got we=%b addr=%0d data=%h, want %b %0d %h",
                         c, RegWrite, waddr, wdata, mwe, maddr, mdata);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mstarve     = 0;
        mwe         = 1'b0;
        maddr       = 5'd0;
        mdata       = 32'd0;
        Rst         = 1'b1;
        pipe_valid  = 1'b0;
        pipe_rd     = 5'd0;
        pipe_data   = 32'd0;
        lu_valid    = 1'b0;
        lu_rd       = 5'd0;
        lu_data     = 32'd0;
        #1;
        test_reset();
        test_pipe_only();
        test_lu_path();
        test_fifo_full();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter sitting directly upstream of the register file; owns its single write port (RegWrite/waddr/wdata).
- Merges two result sources:
  - the in-order pipeline writeback stage (single-cycle, never back-pressured except by the starvation stall);
  - a long-latency unit (divider/load miss) via valid/ready.
- Buffers long-latency results in a small FIFO and exports a pending-destination mask for decode-stage WAW/RAW interlocks.

Parameters:
- DEPTH, 2, FIFO entries for long-latency results; power of two, >= 2.
- STARVE_LIMIT, 4, consecutive cycles the pipeline may win while the FIFO is non-empty before a forced drain.

Ports:
- Clk  input  1  clock, all state on posedge.
- Rst  input  1  synchronous, active-high reset.
- pipe_valid  input  1  pipeline has a writeback this cycle.
- pipe_rd  input  5  pipeline destination register.
- pipe_data  input  32  pipeline result.
- pipe_stall  output  1  combinational; pipeline must hold its WB stage and re-present it next cycle.
- lu_valid  input  1  long-latency result offered.
- lu_rd  input  5  long-latency destination register.
- lu_data  input  32  long-latency result.
- lu_ready  output  1  combinational; accept when lu_valid & lu_ready.
- RegWrite  output  1  registered write enable to the register file.
- waddr  output  5  registered write address.
- wdata  output  32  registered write data.
- pending  output  32  combinational; bit i set iff a valid FIFO entry targets register i (bit 0 always 0).

Behaviour:
- Reset (Rst high at posedge):
  - FIFO count, read and write pointers, and starvation counter go to 0.
  - RegWrite=0, waddr=0, wdata=0.
  - While Rst is high: lu_ready=0, pipe_stall=0, pending=0.
  - A reset asserted mid-operation discards all buffered entries; no write issues in the cycle after reset.
- Definitions:
  - pipe_req = pipe_valid & (pipe_rd != 0)
  - fifo_ne = count != 0
  - full = (count == DEPTH)
- Acceptance:
  - lu_ready = !full & !Rst.
  - Handshake: lu_valid & lu_ready.
  - A handshaked result with lu_rd == 0 is consumed and dropped (never enqueued).
  - lu_valid may drop without a handshake; no state changes.
- Arbitration, evaluated each cycle, result registered at posedge (1-cycle latency to the write port):
  - force = fifo_ne & (starve_cnt == STARVE_LIMIT).
  - If force: pop the FIFO head onto the write port and assert pipe_stall=1. The pipeline entry is ignored this cycle and must be re-presented.
  - Else if pipe_req: emit the pipeline entry. pipe_stall=0.
  - Else if fifo_ne: pop the FIFO head and emit it.
  - Else: RegWrite=0; waddr/wdata hold their previous values.
- Starvation counter:
  - Increments when pipe_req wins while fifo_ne.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO:
  - No bypass: an entry pushed on cycle N can pop no earlier than N+1, so the minimum long-latency-to-RegWrite latency is 2 cycles.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Order is strict FIFO.
- Pending mask:
  - Reflects FIFO contents before the current cycle's push/pop.
  - An entry clears from `pending` in the cycle after it pops. In that same cycle it is on the write port; the regfile commits it on that negedge.
- Pipeline writes with pipe_rd == 0 never assert RegWrite and do not block a FIFO pop.
- WAW ordering between the two sources is decode's responsibility via `pending`. The block does not reorder or compare addresses.

Test Plan:
- Reset then idle: Rst=1 for 2 cycles, then deassert, no stimulus → RegWrite=0, waddr=0, wdata=0, lu_ready=1, pending=0.
- Pipeline only: pipe_valid=1, rd=5, data=0xDEADBEEF at cycle N → RegWrite=1, waddr=5, wdata=0xDEADBEEF after posedge N. pipe_rd=0 the next cycle → RegWrite=0.
- Long-latency path with no pipeline traffic: push rd=7, data=0x12345678 at N → pending[7]=1 at N+1; RegWrite/waddr=7 after posedge N+1; pending[7]=0 at N+2.
- FIFO full: pipe_req held high, push rd=1 then rd=2 → count=2, lu_ready=0, third lu_valid is not accepted. Pops occur in order 1 then 2.
- Starvation: FIFO holds rd=3 and pipe_req is continuous → 4 pipeline writes, then cycle 5 has pipe_stall=1 and waddr=3 written. The pipeline entry is re-presented and written in the following cycle.
- Reset mid-operation: FIFO holds 2 entries and Rst pulses for 1 cycle → pending=0, no FIFO writes ever appear, lu_ready=1 after reset.
